// File: rtl/softmax_max_sub.sv
// Softmax front stage: finds the vector maximum through a registered comparator
// tree and outputs every element minus that maximum, saturated to W bits.
module softmax_max_sub #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           valid_in,
  input  logic [N*W-1:0] in_x_flat,
  output logic           valid_out,
  output logic [W-1:0]   max_out,
  output logic [N*W-1:0] out_flat
);

  localparam int LG = $clog2(N);

  // x_pipe[0] is the input register; later entries keep the vector aligned with the tree.
  logic [N*W-1:0] x_pipe [0:LG];
  logic [LG:0]    v_pipe;

  // Heap-indexed tree: node 1 is the root, node j has children 2j and 2j+1,
  // and children at index >= N are the leaves taken from x_pipe[0].
  logic [W-1:0]   node_reg  [1:N-1];
  logic [W-1:0]   node_next [1:N-1];
  logic [N*W-1:0] out_next;

  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_node
      logic [W-1:0] a;
      logic [W-1:0] b;
      if (2 * gi >= N) begin : g_leaf
        assign a = x_pipe[0][W*(2*gi-N) +: W];
        assign b = x_pipe[0][W*(2*gi+1-N) +: W];
      end else begin : g_inner
        assign a = node_reg[2*gi];
        assign b = node_reg[2*gi+1];
      end
      assign node_next[gi] = ($signed(a) >= $signed(b)) ? a : b;
    end

    for (gi = 0; gi < N; gi++) begin : g_sub
      logic [W-1:0]   xe;
      logic signed [W:0] d;
      assign xe = x_pipe[LG][W*gi +: W];
      assign d  = $signed({xe[W-1], xe}) - $signed({node_reg[1][W-1], node_reg[1]});
      // The difference is never positive, so only the negative bound can be crossed.
      assign out_next[W*gi +: W] = (d[W] && !d[W-1]) ? {1'b1, {(W-1){1'b0}}} : d[W-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= LG; k++) x_pipe[k] <= '0;
      for (int j = 1; j < N; j++) node_reg[j] <= '0;
      v_pipe    <= '0;
      valid_out <= 1'b0;
      max_out   <= '0;
      out_flat  <= '0;
    end else if (en) begin
      x_pipe[0] <= in_x_flat;
      for (int k = 1; k <= LG; k++) x_pipe[k] <= x_pipe[k-1];
      for (int j = 1; j < N; j++) node_reg[j] <= node_next[j];
      v_pipe    <= {v_pipe[LG-1:0], valid_in};
      valid_out <= v_pipe[LG];
      max_out   <= node_reg[1];
      out_flat  <= out_next;
    end
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed-vector bench for softmax_max_sub: latency, max, subtraction,
// saturation, back-to-back flow, stalls and mid-stream reset.
module tb_softmax_max_sub;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           valid_in;
  logic [N*W-1:0] in_x_flat;
  logic           valid_out;
  logic [W-1:0]   max_out;
  logic [N*W-1:0] out_flat;

  softmax_max_sub #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (valid_in),
    .in_x_flat (in_x_flat),
    .valid_out (valid_out),
    .max_out   (max_out),
    .out_flat  (out_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] x;
    logic [W-1:0]   mx;
    logic [N*W-1:0] y;
  } vec_t;

  vec_t tbl [5];
  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic chk_vec(input string name, input int idx);
    chk($sformatf("%s valid", name), {{(N*W-1){1'b0}}, valid_out}, 1);
    chk($sformatf("%s max", name), {{(N*W-W){1'b0}}, max_out}, {{(N*W-W){1'b0}}, tbl[idx].mx});
    chk($sformatf("%s out", name), out_flat, tbl[idx].y);
    $display("vec %0d %s: max=%h out=%h", idx, name, max_out, out_flat);
  endtask

  task automatic run_single(input int idx, input string tag);
    int lat;
    in_x_flat = tbl[idx].x;
    valid_in  = 1'b1;
    step();
    valid_in  = 1'b0;
    in_x_flat = '0;
    lat = 1;
    while (valid_out !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk($sformatf("%s latency", tag), lat, 5);
    chk_vec(tag, idx);
    step();
    chk($sformatf("%s single pulse", tag), {{(N*W-1){1'b0}}, valid_out}, 0);
  endtask

  initial begin
    logic           snap_v;
    logic [W-1:0]   snap_m;
    logic [N*W-1:0] snap_o;
    int ord [3];

    tbl[0].x  = {16'h061D, 16'h061D, 16'hFDE2, 16'h0B13, 16'hFBCF, 16'h0B26, 16'h042B, 16'hF5BE};
    tbl[0].mx = 16'h0B26;
    tbl[0].y  = {16'hFAF7, 16'hFAF7, 16'hF2BC, 16'hFFED, 16'hF0A9, 16'h0000, 16'hF905, 16'hEA98};
    tbl[1].x  = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    tbl[1].mx = 16'h7FFF;
    tbl[1].y  = {16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8000, 16'h0000};
    tbl[2].x  = {8{16'h1234}};
    tbl[2].mx = 16'h1234;
    tbl[2].y  = '0;
    tbl[3].x  = {16'hF800, 16'hF900, 16'hFA00, 16'hFB00, 16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00};
    tbl[3].mx = 16'hFF00;
    tbl[3].y  = {16'hF900, 16'hFA00, 16'hFB00, 16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00, 16'h0000};
    tbl[4].x  = {16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4].mx = 16'h0400;
    tbl[4].y  = {16'h0000, 16'hFC00, 16'hFC00, 16'hFC00, 16'h8000, 16'hFC00, 16'hFC00, 16'hFC00};

    // Reset with random traffic on the inputs
    rst = 1'b1;
    en  = 1'b1;
    valid_in  = 1'b0;
    in_x_flat = '0;
    for (int c = 0; c < 3; c++) begin
      valid_in  = 1'($urandom_range(0, 1));
      in_x_flat = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk($sformatf("reset valid c%0d", c), {{(N*W-1){1'b0}}, valid_out}, 0);
      chk($sformatf("reset max c%0d", c), {{(N*W-W){1'b0}}, max_out}, 0);
      chk($sformatf("reset out c%0d", c), out_flat, 0);
    end
    rst = 1'b0;
    valid_in = 1'b0;
    step();
    chk("post-release valid", {{(N*W-1){1'b0}}, valid_out}, 0);
    chk("post-release max", {{(N*W-W){1'b0}}, max_out}, 0);
    chk("post-release out", out_flat, 0);
    for (int c = 0; c < 6; c++) step();

    // One isolated vector per table entry
    for (int i = 0; i < 5; i++) run_single(i, $sformatf("single%0d", i));

    // Three vectors back to back
    ord = '{0, 1, 3};
    for (int s = 1; s <= 9; s++) begin
      if (s <= 3) begin
        in_x_flat = tbl[ord[s-1]].x;
        valid_in  = 1'b1;
      end else begin
        valid_in  = 1'b0;
        in_x_flat = '0;
      end
      step();
      if (s >= 5 && s <= 7) chk_vec($sformatf("b2b s%0d", s), ord[s-5]);
      else if (s >= 4) chk($sformatf("b2b idle s%0d", s), {{(N*W-1){1'b0}}, valid_out}, 0);
    end

    // Stall with two vectors in flight
    in_x_flat = tbl[2].x; valid_in = 1'b1; step();   // enabled edge 1
    in_x_flat = tbl[4].x; valid_in = 1'b1; step();   // enabled edge 2
    valid_in = 1'b0; in_x_flat = '0;
    step(); step();                                  // enabled edges 3, 4
    snap_v = valid_out; snap_m = max_out; snap_o = out_flat;
    en = 1'b0; valid_in = 1'b1; in_x_flat = tbl[0].x;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("stall valid c%0d", c), {{(N*W-1){1'b0}}, valid_out}, {{(N*W-1){1'b0}}, snap_v});
      chk($sformatf("stall max c%0d", c), {{(N*W-W){1'b0}}, max_out}, {{(N*W-W){1'b0}}, snap_m});
      chk($sformatf("stall out c%0d", c), out_flat, snap_o);
    end
    en = 1'b1; valid_in = 1'b0; in_x_flat = '0;
    step();                                          // enabled edge 5
    chk_vec("stall first", 2);
    en = 1'b0; valid_in = 1'b1; in_x_flat = tbl[3].x;
    for (int c = 0; c < 2; c++) begin
      step();
      chk_vec($sformatf("stall hold c%0d", c), 2);
    end
    en = 1'b1; valid_in = 1'b0; in_x_flat = '0;
    step();                                          // enabled edge 6
    chk_vec("stall second", 4);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("stall drain c%0d", c), {{(N*W-1){1'b0}}, valid_out}, 0);
    end

    // Reset while three vectors are in flight
    for (int s = 0; s < 3; s++) begin
      in_x_flat = tbl[ord[s]].x;
      valid_in  = 1'b1;
      step();
    end
    valid_in = 1'b0; in_x_flat = '0;
    rst = 1'b1;
    step();
    chk("midrst valid", {{(N*W-1){1'b0}}, valid_out}, 0);
    chk("midrst max", {{(N*W-W){1'b0}}, max_out}, 0);
    chk("midrst out", out_flat, 0);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("midrst flush c%0d", c), {{(N*W-1){1'b0}}, valid_out}, 0);
    end
    run_single(4, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
